firebird7_in_gate1_tessent_tdr_data_ctrl_w19: RTL

FIREBIRD7_IN_GATE1_TESSENT_TDR_DATA_CTRL_W19 -- requirements
Module: firebird7_in_gate1_tessent_tdr_data_ctrl_w19

---
 rtl/firebird7_in_gate1_tessent_tdr_data_ctrl_w19.sv | 130 +++++++++++++
 1 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl_w19.sv
// IJTAG test data register controller: a WIDTH+1 bit shift register whose
// top bit is a mux select and whose lower bits are mux data. Capture loads
// the functional observe value, shift moves scan data LSB first, and update
// copies the shift register into the select/data output registers.
module firebird7_in_gate1_tessent_tdr_data_ctrl_w19 #(
  parameter int WIDTH      = 19,
  parameter int STRICT_LEN = 0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  input  logic [WIDTH-1:0] observe_data_in,
  output logic             ijtag_so,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             update_pulse,
  output logic             len_err
);

  // Shift chain length (select bit + data bits) and bit counter sizing.
  localparam int                SR_LEN  = WIDTH + 1;
  localparam int                CNT_W   = $clog2(2 * SR_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(2 * SR_LEN);
  localparam logic [CNT_W-1:0]  CNT_LEN = CNT_W'(SR_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [WIDTH:0]   sr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             select_r;
  logic [WIDTH-1:0] data_r;
  logic             pulse_r;
  logic             len_err_r;

  logic             capture_s;
  logic             shift_s;
  logic             upd_req_s;
  logic             len_ok_s;
  logic             upd_apply_s;
  logic [WIDTH:0]   sr_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             len_err_nxt_s;

  // Decode enables and compute next shift register, bit count and error flag.
  always_comb begin
    capture_s     = ijtag_sel & ijtag_ce;
    shift_s       = ijtag_sel & ijtag_se & ~ijtag_ce;
    upd_req_s     = ijtag_sel & ijtag_ue;
    len_ok_s      = 1'b1;
    sr_nxt_s      = sr_r;
    cnt_nxt_s     = cnt_r;
    len_err_nxt_s = len_err_r;

    // Length check looks at the count as it stood before this edge.
    if (STRICT_LEN != 0) begin
      len_ok_s = (cnt_r == CNT_LEN);
    end else begin
      len_ok_s = 1'b1;
    end

    upd_apply_s = upd_req_s & len_ok_s;

    // Capture wins over shift; the select bit is read back as currently applied.
    if (capture_s) begin
      sr_nxt_s  = {select_r, observe_data_in};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (shift_s) begin
      sr_nxt_s = {ijtag_si, sr_r[WIDTH:1]};
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      sr_nxt_s  = sr_r;
      cnt_nxt_s = cnt_r;
    end

    // A rejected update flags the error even if a capture shares the edge.
    if (upd_req_s && !len_ok_s) begin
      len_err_nxt_s = 1'b1;
    end else if (capture_s) begin
      len_err_nxt_s = 1'b0;
    end else begin
      len_err_nxt_s = len_err_r;
    end
  end

  // Shift register, bit counter and sticky length error state.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr_r      <= {(WIDTH + 1){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      len_err_r <= 1'b0;
    end else begin
      sr_r      <= sr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      len_err_r <= len_err_nxt_s;
    end
  end

  // Update registers take the pre-edge shift register; strobe follows each applied update.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      select_r <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
      pulse_r  <= 1'b0;
    end else begin
      if (upd_apply_s) begin
        select_r <= sr_r[WIDTH];
        data_r   <= sr_r[WIDTH-1:0];
      end else begin
        select_r <= select_r;
        data_r   <= data_r;
      end
      pulse_r <= upd_apply_s;
    end
  end

  // Scan out is the live LSB so the next segment sees it without retiming.
  assign ijtag_so       = sr_r[0];
  assign ijtag_select   = select_r;
  assign ijtag_data_out = data_r;
  assign update_pulse   = pulse_r;
  assign len_err        = len_err_r;

endmodule
